// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e : 4-bit HI/LO operation encodings
//   - state_e : two-state sequencing FSM encoding
//   - MUL_LAT / DIV_LAT : busy-cycle counts for multiply and divide
//   - is_mul_class / is_div_class : op classification helpers
// Optional feature macro: MD_MADD_EN (multiply-accumulate ops count as
// multiply-class only when defined).
package md_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  function automatic logic is_mul_class(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit result generator for md_unit.
// Ports:
//   op      - latched operation
//   a, b    - latched operands (rs, rt)
//   hi, lo  - current HI/LO (accumulator source)
//   new_hi, new_lo - values to write into HI/LO
//   wr_en   - result is valid and should be written
// Optional feature macro: MD_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
module md_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] new_hi,
  output logic [31:0] new_lo,
  output logic        wr_en
);
  import md_pkg::*;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divisor forced non-zero so the dividers never see x; a zero divisor
  // suppresses the write below anyway.
  assign b_safe = (b == '0) ? 32'd1 : b;
  assign q_s    = $signed(a) / $signed(b_safe);
  assign r_s    = $signed(a) % $signed(b_safe);
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  always_comb begin
    new_hi = hi;
    new_lo = lo;
    wr_en  = 1'b0;
    case (op)
      OP_MULT:  begin {new_hi, new_lo} = prod_s; wr_en = 1'b1; end
      OP_MULTU: begin {new_hi, new_lo} = prod_u; wr_en = 1'b1; end
      OP_DIV: begin
        new_lo = q_s;
        new_hi = r_s;
        wr_en  = (b != '0);
      end
      OP_DIVU: begin
        new_lo = q_u;
        new_hi = r_u;
        wr_en  = (b != '0);
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin {new_hi, new_lo} = {hi, lo} + prod_s; wr_en = 1'b1; end
      OP_MADDU: begin {new_hi, new_lo} = {hi, lo} + prod_u; wr_en = 1'b1; end
      OP_MSUB:  begin {new_hi, new_lo} = {hi, lo} - prod_s; wr_en = 1'b1; end
      OP_MSUBU: begin {new_hi, new_lo} = {hi, lo} - prod_u; wr_en = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative-latency multiply/divide unit with HI/LO registers.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   start   - op issues this cycle (E stage)
//   md_op   - operation (md_pkg::md_op_e encoding)
//   rs_val  - first operand
//   rt_val  - second operand
//   md_use  - D-stage instruction needs the unit
//   busy    - multi-cycle operation in flight
//   stall   - D-stage freeze request
//   md_out  - MFHI/MFLO read value
// Optional feature macro: MD_MADD_EN (multiply-accumulate ops).
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_out
);
  import md_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_wr;

  md_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .new_hi (calc_hi),
    .new_lo (calc_lo),
    .wr_en  (calc_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_class(md_op) || is_div_class(md_op)) begin
            op_d    = md_op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = is_div_class(md_op) ? DIV_LAT : MUL_LAT;
            state_d = ST_BUSY;
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        // start is ignored here; writeback happens on the final count.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (calc_wr) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = md_use & (busy | (start & (is_mul_class(md_op) | is_div_class(md_op))));

  always_comb begin
    md_out = '0;
    if (md_op == OP_MFHI)      md_out = hi_q;
    else if (md_op == OP_MFLO) md_out = lo_q;
  end

endmodule
